// File: rtl/pong_if.sv
// Game-side bundle of the pong engine: tick/start/paddle bitmaps in, ball, scores and status out.
// The engine attaches through the slave modport; the game controller drives the master side.
interface pong_if #(
  parameter int COLS = 16,
  parameter int ROWS = 16
) ();
  logic                    tick;
  logic                    start;
  logic [ROWS-1:0]         lpaddle;
  logic [ROWS-1:0]         rpaddle;
  logic [$clog2(COLS)-1:0] x;
  logic [$clog2(ROWS)-1:0] y;
  logic [3:0]              score_p1;
  logic [3:0]              score_p2;
  logic [2:0]              state;
  logic                    winner;
  logic                    hit;
  logic                    point;

  modport master (
    output tick, start, lpaddle, rpaddle,
    input  x, y, score_p1, score_p2, state, winner, hit, point
  );

  modport slave (
    input  tick, start, lpaddle, rpaddle,
    output x, y, score_p1, score_p2, state, winner, hit, point
  );
endinterface

// File: rtl/pong_engine.sv
// Pong game core for a COLS x ROWS LED matrix: ball physics, paddle deflection, speed-up, scoring
// and match FSM. Define AUTO_SERVE_EN to let SERVE launch the ball by itself after HOLD_TICKS ticks.
module pong_engine #(
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int SPEED_INIT = 20,
  parameter int SPEED_MIN  = 5,
  parameter int SPEED_STEP = 1,
  parameter int WIN_SCORE  = 9,
  parameter int HOLD_TICKS = 500
) (
  input logic  clk,
  input logic  reset,
  pong_if.slave bus
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int PW = $clog2(SPEED_INIT + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [XW-1:0] X_MID = XW'(COLS / 2);
  localparam logic [YW-1:0] Y_MID = YW'(ROWS / 2);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
  localparam logic [PW-1:0] P_INIT = PW'(SPEED_INIT);
  localparam logic [3:0]    S_WIN = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  typedef enum logic [1:0] {DY_ZERO, DY_POS, DY_NEG} dy_t;

  state_t        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          dx_pos;
  dy_t           dy_q;
  logic [PW-1:0] period_q;
  logic [PW-1:0] step_cnt;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    score_p1_q;
  logic [3:0]    score_p2_q;
  logic          winner_q;
  logic          hit_q;
  logic          point_q;
  logic          start_q;

  logic start_rise, hold_done, step_done, scorer_won, enter_serve;

  assign start_rise = bus.start & ~start_q;
  assign hold_done  = (hold_cnt == HW'(HOLD_TICKS - 1));
  assign step_done  = (step_cnt == period_q - PW'(1));
  // While frozen in POINT the ball still moves toward the conceding side, so dx names the scorer.
  assign scorer_won = dx_pos ? (score_p1_q == S_WIN) : (score_p2_q == S_WIN);
  assign enter_serve = ((state_q == S_IDLE || state_q == S_GAMEOVER) && start_rise) ||
                       (state_q == S_POINT && bus.tick && hold_done && !scorer_won);

  // Per-step kinematics, evaluated every cycle and used only when a step fires.
  dy_t             dy_wall, dy_hit;
  logic [YW-1:0]   y_moved;
  logic            at_left, at_right, paddle_hit, paddle_miss, edge_top, edge_bot;
  logic [ROWS-1:0] pad;
  logic [ROWS+1:0] pad_ext;
  logic [YW:0]     y_ext;
  logic [PW-1:0]   period_dec;
  int              period_sub;

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    dy_wall = dy_q;
    if (y_q == '0 && dy_q == DY_NEG)         dy_wall = DY_POS;
    else if (y_q == Y_MAX && dy_q == DY_POS) dy_wall = DY_NEG;

    unique case (dy_wall)
      DY_POS:  y_moved = y_q + YW'(1);
      DY_NEG:  y_moved = y_q - YW'(1);
      default: y_moved = y_q;
    endcase

    at_left     = (x_q == XW'(1)) && !dx_pos;
    at_right    = (x_q == XW'(COLS - 2)) && dx_pos;
    pad         = at_left ? bus.lpaddle : bus.rpaddle;
    paddle_hit  = (at_left || at_right) && pad[y_q];
    paddle_miss = (at_left || at_right) && !pad[y_q];

    // Zero-padded bitmap: the matrix edge counts as an unlit neighbour of the paddle.
    pad_ext  = {1'b0, pad, 1'b0};
    y_ext    = {1'b0, y_q};
    edge_top = ~pad_ext[y_ext];
    edge_bot = ~pad_ext[y_ext + (YW+1)'(2)];

    dy_hit = dy_wall;
    if (edge_top && !edge_bot)      dy_hit = DY_NEG;
    else if (edge_bot && !edge_top) dy_hit = DY_POS;
    if (y_moved == '0 && dy_hit == DY_NEG)         dy_hit = DY_POS;
    else if (y_moved == Y_MAX && dy_hit == DY_POS) dy_hit = DY_NEG;

    period_sub = int'(period_q) - SPEED_STEP;
    if (period_sub < SPEED_MIN) period_sub = SPEED_MIN;
    period_dec = PW'(period_sub);
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously on reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= X_MID;
      y_q        <= Y_MID;
      dx_pos     <= 1'b1;
      dy_q       <= DY_ZERO;
      period_q   <= P_INIT;
      step_cnt   <= '0;
      hold_cnt   <= '0;
      score_p1_q <= '0;
      score_p2_q <= '0;
      winner_q   <= 1'b0;
      hit_q      <= 1'b0;
      point_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q <= bus.start;
      hit_q   <= 1'b0;
      point_q <= 1'b0;

      unique case (state_q)
        S_IDLE: ;

        S_SERVE: begin
          if (start_rise) begin
            state_q  <= S_PLAY;
            step_cnt <= '0;
          end
`ifdef AUTO_SERVE_EN
          else if (bus.tick) begin
            if (hold_done) begin
              state_q  <= S_PLAY;
              step_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
`endif
        end

        S_PLAY: begin
          if (bus.tick) begin
            if (!step_done) begin
              step_cnt <= step_cnt + PW'(1);
            end else begin
              step_cnt <= '0;
              y_q      <= y_moved;
              if (paddle_hit) begin
                x_q      <= at_left ? XW'(2) : XW'(COLS - 3);
                dx_pos   <= at_left;
                dy_q     <= dy_hit;
                period_q <= period_dec;
                hit_q    <= 1'b1;
              end else if (paddle_miss) begin
                x_q      <= at_left ? '0 : XW'(COLS - 1);
                dy_q     <= dy_wall;
                point_q  <= 1'b1;
                hold_cnt <= '0;
                state_q  <= S_POINT;
                if (at_left && score_p2_q != S_WIN)  score_p2_q <= score_p2_q + 4'd1;
                if (at_right && score_p1_q != S_WIN) score_p1_q <= score_p1_q + 4'd1;
              end else begin
                x_q  <= dx_pos ? x_q + XW'(1) : x_q - XW'(1);
                dy_q <= dy_wall;
              end
            end
          end
        end

        S_POINT: begin
          if (bus.tick) begin
            if (!hold_done) begin
              hold_cnt <= hold_cnt + HW'(1);
            end else if (scorer_won) begin
              state_q  <= S_GAMEOVER;
              winner_q <= !dx_pos;
            end
          end
        end

        S_GAMEOVER: begin
          if (start_rise) begin
            score_p1_q <= '0;
            score_p2_q <= '0;
            dx_pos     <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // Serve setup overrides whatever the branch above did to the ball.
      if (enter_serve) begin
        state_q  <= S_SERVE;
        x_q      <= X_MID;
        y_q      <= Y_MID;
        dy_q     <= DY_ZERO;
        period_q <= P_INIT;
        step_cnt <= '0;
        hold_cnt <= '0;
      end
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.score_p1 = score_p1_q;
  assign bus.score_p2 = score_p2_q;
  assign bus.state    = state_q;
  assign bus.winner   = winner_q;
  assign bus.hit      = hit_q;
  assign bus.point    = point_q;
endmodule
